// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
//
// Supervises one program run on the 32-bit microprocessor system. It counts
// cycles, emits periodic progress pulses with a pc snapshot, snoops writes to
// the status word, and ends the run on halt, timeout or pc stall. The final
// verdict is latched.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         pulse; begins a monitored run (ignored while a run is active)
//   halted        CPU system_halted
//   pc            CPU program counter
//   wr_en/wr_addr/wr_data   memory write snoop
//   ext_access    external memory read or write strobe
//   busy          run in progress
//   done          verdict valid, held until the next start or rst
//   verdict       0 NONE, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT, 5 STALL
//   cycle_count   cycles elapsed in the current or last run
//   ext_count     external accesses in the run, saturating
//   status_value  last value written to the status word
//   status_seen   at least one status write happened in this run
//   progress      one-cycle pulse every PROGRESS_INTERVAL run cycles
//   progress_pc   pc sampled at the last progress pulse
// -----------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    CYC_WIDTH         = 32,
    parameter int                    MAX_CYCLES        = 10000,
    parameter int                    PROGRESS_INTERVAL = 100,
    parameter int                    STALL_LIMIT       = 1024,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR       = 32'h0000_2000,
    parameter int                    PASS_CODE         = 1,
    parameter int                    FAIL_CODE         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halted,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ext_access,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            verdict,
    output logic [CYC_WIDTH-1:0]  cycle_count,
    output logic [CYC_WIDTH-1:0]  ext_count,
    output logic [DATA_WIDTH-1:0] status_value,
    output logic                  status_seen,
    output logic                  progress,
    output logic [ADDR_WIDTH-1:0] progress_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] V_NONE    = 3'd0;
    localparam logic [2:0] V_PASS    = 3'd1;
    localparam logic [2:0] V_FAIL    = 3'd2;
    localparam logic [2:0] V_UNKNOWN = 3'd3;
    localparam logic [2:0] V_TIMEOUT = 3'd4;
    localparam logic [2:0] V_STALL   = 3'd5;

    // Counter widths sized so the load / limit values always fit.
    localparam int PW = $clog2(PROGRESS_INTERVAL + 2);
    localparam int SW = $clog2(STALL_LIMIT + 2);

    localparam logic [PW-1:0]         PROG_LOAD = PW'(PROGRESS_INTERVAL);
    localparam logic [SW-1:0]         STALL_M1  = SW'(STALL_LIMIT - 1);
    localparam logic [CYC_WIDTH-1:0]  MAX_M1    = CYC_WIDTH'(MAX_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] PASS_C    = DATA_WIDTH'(PASS_CODE);
    localparam logic [DATA_WIDTH-1:0] FAIL_C    = DATA_WIDTH'(FAIL_CODE);

    state_t                  state_q, state_d;
    logic [2:0]              verdict_q, verdict_d;
    logic [CYC_WIDTH-1:0]    cycle_q;
    logic [CYC_WIDTH-1:0]    ext_q;
    logic [DATA_WIDTH-1:0]   status_value_q;
    logic                    status_seen_q;
    logic [ADDR_WIDTH-1:0]   progress_pc_q;
    logic [PW-1:0]           prog_q;
    logic [SW-1:0]           stall_q;
    logic [ADDR_WIDTH-1:0]   prev_pc_q;
    logic                    first_q;

    logic                    launch;
    logic                    in_run;
    logic                    snoop_hit;
    logic                    pc_changed;
    logic [SW-1:0]           stall_cur;
    logic                    stall_hit;
    logic                    timeout_hit;
    logic                    progress_hit;
    logic                    eff_seen;
    logic [DATA_WIDTH-1:0]   eff_value;
    logic [2:0]              status_verdict;

    // Run-condition decode. The stall count for the current cycle is formed
    // combinationally so the limit check sees this cycle's pc, and a status
    // write in the halt cycle is bypassed straight into the verdict.
    always_comb begin
        in_run       = (state_q == RUN);
        launch       = start && (state_q != RUN);
        snoop_hit    = in_run && wr_en && (wr_addr == STATUS_ADDR);
        pc_changed   = first_q || (pc != prev_pc_q);
        stall_cur    = pc_changed ? '0 : stall_q + SW'(1);
        stall_hit    = (STALL_LIMIT != 0) && (stall_cur == STALL_M1);
        timeout_hit  = (cycle_q == MAX_M1);
        progress_hit = (PROGRESS_INTERVAL != 0) && in_run && (prog_q == PW'(1));
        eff_seen     = status_seen_q || snoop_hit;
        eff_value    = snoop_hit ? wr_data : status_value_q;
        if (!eff_seen) begin
            status_verdict = V_UNKNOWN;
        end else if (eff_value == PASS_C) begin
            status_verdict = V_PASS;
        end else if (eff_value == FAIL_C) begin
            status_verdict = V_FAIL;
        end else begin
            status_verdict = V_UNKNOWN;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and verdict selection; halt beats timeout beats stall.
    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    verdict_d = V_NONE;
                end
            end
            RUN: begin
                if (halted) begin
                    state_d   = DONE;
                    verdict_d = status_verdict;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    verdict_d = V_TIMEOUT;
                end else if (stall_hit) begin
                    state_d   = DONE;
                    verdict_d = V_STALL;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    verdict_d = V_NONE;
                end
            end
            default: begin
                state_d   = IDLE;
                verdict_d = V_NONE;
            end
        endcase
    end

    // Run datapath: everything is cleared on launch and only advances in RUN,
    // so values are naturally frozen in IDLE and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verdict_q      <= V_NONE;
            cycle_q        <= '0;
            ext_q          <= '0;
            status_value_q <= '0;
            status_seen_q  <= 1'b0;
            progress_pc_q  <= '0;
            prog_q         <= '0;
            stall_q        <= '0;
            prev_pc_q      <= '0;
            first_q        <= 1'b0;
        end else if (launch) begin
            verdict_q      <= verdict_d;
            cycle_q        <= '0;
            ext_q          <= '0;
            status_value_q <= '0;
            status_seen_q  <= 1'b0;
            progress_pc_q  <= '0;
            prog_q         <= PROG_LOAD;
            stall_q        <= '0;
            prev_pc_q      <= '0;
            first_q        <= 1'b1;
        end else if (in_run) begin
            verdict_q <= verdict_d;
            cycle_q   <= cycle_q + CYC_WIDTH'(1);
            if (ext_access && (ext_q != '1)) begin
                ext_q <= ext_q + CYC_WIDTH'(1);
            end
            if (snoop_hit) begin
                status_value_q <= wr_data;
                status_seen_q  <= 1'b1;
            end
            prog_q <= (prog_q == PW'(1)) ? PROG_LOAD : prog_q - PW'(1);
            if (progress_hit) begin
                progress_pc_q <= pc;
            end
            stall_q   <= stall_cur;
            prev_pc_q <= pc;
            first_q   <= 1'b0;
        end
    end

    // Output mapping.
    always_comb begin
        busy         = (state_q == RUN);
        done         = (state_q == DONE);
        verdict      = verdict_q;
        cycle_count  = cycle_q;
        ext_count    = ext_q;
        status_value = status_value_q;
        status_seen  = status_seen_q;
        progress     = progress_hit;
        progress_pc  = progress_pc_q;
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Directed bench for cpu_run_monitor. The main instance uses MAX_CYCLES=300,
// PROGRESS_INTERVAL=100, STALL_LIMIT=16; a second instance with a 4-bit
// counter width and MAX_CYCLES=16 shares the inputs and is used for the
// ext_count saturation case. Inputs change on the falling edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halted;
    logic [31:0] pc;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        ext_access;

    logic        busy, done, status_seen, progress;
    logic [2:0]  verdict;
    logic [31:0] cycle_count, ext_count, status_value, progress_pc;

    logic        sBusy, sDone, sStatusSeen, sProgress;
    logic [2:0]  sVerdict;
    logic [3:0]  sCycleCount, sExtCount;
    logic [31:0] sStatusValue, sProgressPc;

    int totalChecks = 0;
    int badChecks   = 0;
    int pulses;
    int firstPulse;

    cpu_run_monitor #(
        .MAX_CYCLES(300), .PROGRESS_INTERVAL(100), .STALL_LIMIT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halted(halted), .pc(pc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ext_access(ext_access), .busy(busy), .done(done), .verdict(verdict),
        .cycle_count(cycle_count), .ext_count(ext_count),
        .status_value(status_value), .status_seen(status_seen),
        .progress(progress), .progress_pc(progress_pc)
    );

    cpu_run_monitor #(
        .CYC_WIDTH(4), .MAX_CYCLES(16), .PROGRESS_INTERVAL(0), .STALL_LIMIT(0)
    ) dutSat (
        .clk(clk), .rst(rst), .start(start), .halted(halted), .pc(pc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ext_access(ext_access), .busy(sBusy), .done(sDone), .verdict(sVerdict),
        .cycle_count(sCycleCount), .ext_count(sExtCount),
        .status_value(sStatusValue), .status_seen(sStatusSeen),
        .progress(sProgress), .progress_pc(sProgressPc)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one program: start pulse, then per run cycle k drive pc, an optional
    // status write, halt and a restart attempt, until done or the budget ends.
    task automatic applyStimulus(input int haltAt, input int writeAt,
                                 input logic [31:0] writeVal, input int stallFrom,
                                 input bit toggle, input int restartAt,
                                 input int budget, input bit expectEnd);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        pulses     = 0;
        firstPulse = -1;
        for (int k = 0; k < budget; k++) begin
            if (done) break;
            if (k == 0) begin
                checkOutput("run0_busy", {31'd0, busy}, 32'd1);
                checkOutput("run0_cycle", cycle_count, 32'd0);
                checkOutput("run0_verdict", {29'd0, verdict}, 32'd0);
            end
            if (progress) begin
                pulses++;
                if (firstPulse < 0) firstPulse = k;
            end
            if (toggle)
                pc = k[0] ? 32'h44 : 32'h40;
            else if (stallFrom >= 0 && k >= stallFrom)
                pc = 32'h40;
            else
                pc = 32'h1000 + 32'(4 * k);
            wr_en      = (k == writeAt);
            wr_addr    = 32'h2000;
            wr_data    = writeVal;
            halted     = (k == haltAt);
            start      = (k == restartAt);
            ext_access = (k % 3 == 0);
            @(negedge clk);
        end
        start      = 1'b0;
        halted     = 1'b0;
        wr_en      = 1'b0;
        ext_access = 1'b0;
        if (expectEnd) checkOutput("end_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halted = 1'b0; pc = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; ext_access = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_verdict", {29'd0, verdict}, 32'd0);
        checkOutput("rst_cycle", cycle_count, 32'd0);
        checkOutput("rst_progress", {31'd0, progress}, 32'd0);
        rst = 1'b0;

        // Happy path: write 1 at cycle 50, halt at 200; ext every 3rd cycle 0..198.
        applyStimulus(200, 50, 32'd1, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("happy_verdict", {29'd0, verdict}, 32'd1);
        checkOutput("happy_cycle", cycle_count, 32'd201);
        checkOutput("happy_status", status_value, 32'd1);
        checkOutput("happy_seen", {31'd0, status_seen}, 32'd1);
        checkOutput("happy_ext", ext_count, 32'd67);
        checkOutput("happy_busy", {31'd0, busy}, 32'd0);
        checkOutput("happy_pulses", 32'(pulses), 32'd2);

        // Fail code.
        applyStimulus(80, 30, 32'd0, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("fail_verdict", {29'd0, verdict}, 32'd2);
        checkOutput("fail_cycle", cycle_count, 32'd81);

        // Unrecognised code.
        applyStimulus(80, 30, 32'd7, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("code7_verdict", {29'd0, verdict}, 32'd3);
        checkOutput("code7_status", status_value, 32'd7);

        // No status write at all.
        applyStimulus(60, -1, 32'd1, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("nowr_verdict", {29'd0, verdict}, 32'd3);
        checkOutput("nowr_seen", {31'd0, status_seen}, 32'd0);

        // Timeout with three progress pulses at cycles 99/199/299.
        applyStimulus(-1, -1, 32'd1, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("tmo_verdict", {29'd0, verdict}, 32'd4);
        checkOutput("tmo_cycle", cycle_count, 32'd300);
        checkOutput("tmo_pulses", 32'(pulses), 32'd3);
        checkOutput("tmo_first", 32'(firstPulse), 32'd99);
        checkOutput("tmo_ppc", progress_pc, 32'h0000_14AC);

        // Stall: pc frozen at 0x40 from cycle 10, limit 16.
        applyStimulus(-1, -1, 32'd1, 10, 1'b0, -1, 400, 1'b1);
        checkOutput("stall_verdict", {29'd0, verdict}, 32'd5);
        checkOutput("stall_cycle", cycle_count, 32'd26);

        // Toggling pc never stalls.
        applyStimulus(60, -1, 32'd1, -1, 1'b1, -1, 400, 1'b1);
        checkOutput("toggle_verdict", {29'd0, verdict}, 32'd3);
        checkOutput("toggle_cycle", cycle_count, 32'd61);

        // Status write in the halt cycle.
        applyStimulus(50, 50, 32'd1, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("same_verdict", {29'd0, verdict}, 32'd1);
        checkOutput("same_cycle", cycle_count, 32'd51);

        // Halt on the last allowed cycle beats timeout.
        applyStimulus(299, 10, 32'd1, -1, 1'b0, -1, 400, 1'b1);
        checkOutput("hmax_verdict", {29'd0, verdict}, 32'd1);
        checkOutput("hmax_cycle", cycle_count, 32'd300);

        // start during RUN is ignored.
        applyStimulus(40, 5, 32'd1, -1, 1'b0, 20, 400, 1'b1);
        checkOutput("rerun_cycle", cycle_count, 32'd41);
        checkOutput("rerun_verdict", {29'd0, verdict}, 32'd1);

        // Reset mid-run after a status write and a progress pulse.
        applyStimulus(-1, 5, 32'd1, -1, 1'b0, -1, 150, 1'b0);
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        checkOutput("mid_ppc", progress_pc, 32'h0000_118C);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_verdict", {29'd0, verdict}, 32'd0);
        checkOutput("abort_cycle", cycle_count, 32'd0);
        checkOutput("abort_ext", ext_count, 32'd0);
        checkOutput("abort_status", status_value, 32'd0);
        checkOutput("abort_seen", {31'd0, status_seen}, 32'd0);
        checkOutput("abort_ppc", progress_pc, 32'd0);
        rst = 1'b0;

        // Saturation on the 4-bit instance: 16 accesses in a 16-cycle run.
        @(negedge clk);
        start      = 1'b1;
        ext_access = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        ext_access = 1'b0;
        checkOutput("sat_done", {31'd0, sDone}, 32'd1);
        checkOutput("sat_verdict", {29'd0, sVerdict}, 32'd4);
        checkOutput("sat_ext", {28'd0, sExtCount}, 32'd15);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    // Hard time bound so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run monitor that supervises one program execution on the 32-bit microprocessor system.
- Counts cycles and emits periodic progress pulses with PC snapshots.
- Snoops writes to a configurable status word, detects halt, timeout and PC-stall, and produces a latched verdict.
- Sits beside microprocessor_system, in the FPGA top and in benches, replacing ad-hoc pass/fail checking with one reusable block.

Parameters:
- ADDR_WIDTH, 32, width of pc and snooped write address
- DATA_WIDTH, 32, width of snooped write data and status_value
- CYC_WIDTH, 32, width of cycle and access counters
- MAX_CYCLES, 10000, run cycles before TIMEOUT
- PROGRESS_INTERVAL, 100, cycles between progress pulses; 0 disables them
- STALL_LIMIT, 1024, consecutive cycles with unchanged pc before STALL; 0 disables
- STATUS_ADDR, 32'h0000_2000, byte address of the status word
- PASS_CODE, 1, status value meaning pass
- FAIL_CODE, 0, status value meaning fail

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse; begins a monitored run
- halted  input  1  CPU system_halted
- pc  input  ADDR_WIDTH  CPU pc_out
- wr_en  input  1  memory write strobe (snoop)
- wr_addr  input  ADDR_WIDTH  memory write byte address
- wr_data  input  DATA_WIDTH  memory write data
- ext_access  input  1  ext_mem_read OR ext_mem_write
- busy  output  1  run in progress
- done  output  1  verdict valid, held until next start or rst
- verdict  output  3  0 NONE, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT, 5 STALL
- cycle_count  output  CYC_WIDTH  cycles elapsed in current/last run
- ext_count  output  CYC_WIDTH  external accesses, saturating
- status_value  output  DATA_WIDTH  last value written to STATUS_ADDR
- status_seen  output  1  at least one status write occurred this run
- progress  output  1  one-cycle pulse every PROGRESS_INTERVAL cycles
- progress_pc  output  ADDR_WIDTH  pc sampled at the last progress pulse

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0 and verdict=NONE.
- FSM states:
  - IDLE: on start, go to RUN. Clear all counters, status_seen, status_value and progress_pc; load the progress down-counter with PROGRESS_INTERVAL.
  - RUN: busy=1. Each cycle, cycle_count increments by 1. Exits are checked in priority order:
    1. halted=1 goes to DONE with the status-derived verdict.
    2. cycle_count==MAX_CYCLES-1 goes to DONE with TIMEOUT.
    3. Stall counter reaching STALL_LIMIT-1 goes to DONE with STALL.
  - DONE: busy=0, done=1; verdict, counters and status are frozen. start goes to RUN with the same clears as from IDLE.
- Status-derived verdict:
  - status_seen=0 gives UNKNOWN.
  - Otherwise status_value==PASS_CODE gives PASS, ==FAIL_CODE gives FAIL, any other value gives UNKNOWN.
  - A status write in the same cycle as halted=1 is included in the verdict (bypass mux).
- Status snoop: wr_en && wr_addr==STATUS_ADDR in RUN updates status_value and sets status_seen. Ignored in IDLE/DONE.
- ext_count increments on ext_access in RUN and saturates at all-ones.
- Progress:
  - The down-counter decrements each RUN cycle. On reaching 1, progress pulses for one cycle, progress_pc<=pc, and the counter reloads.
  - The first pulse occurs on RUN cycle PROGRESS_INTERVAL (cycle_count==PROGRESS_INTERVAL-1 in the pulse cycle).
  - No pulses outside RUN.
- Stall: the counter resets whenever pc differs from its value in the previous cycle and increments otherwise. The first RUN cycle counts as a change.
- Latency: verdict and done are registered and assert the cycle after the terminating condition. busy deasserts in the same edge.
- start while in RUN is ignored.
- rst asserted mid-run aborts immediately to IDLE with all outputs cleared. No verdict is produced.
- MAX_CYCLES wins over STALL when both fire in the same cycle; halted wins over both.

Test Plan:
- Happy path: start; write 1 to 0x2000 at cycle 50; halted at cycle 200. Required: done=1, verdict=PASS, cycle_count=201 (inclusive of the halt cycle), status_value=1.
- Fail and unknown: write 0 to 0x2000, then halt → FAIL. Write 7, then halt → UNKNOWN. No status write, then halt → UNKNOWN with status_seen=0.
- Timeout: MAX_CYCLES=300, PROGRESS_INTERVAL=100, pc incrementing, never halt. Required: exactly 3 progress pulses with correct progress_pc, then verdict=TIMEOUT and cycle_count=300.
- Stall: STALL_LIMIT=16, pc held at 0x40 from cycle 10. Required: verdict=STALL at cycle 26 (relative to start). Re-run with pc toggling → no STALL.
- Simultaneous events: status write of 1 and halted in the same cycle → PASS. halted on the MAX_CYCLES-1 cycle → PASS, not TIMEOUT.
- Reset and restart: rst mid-run → all outputs 0, verdict NONE. start from DONE → counters cleared and a new run proceeds. start during RUN → no effect. ext_count saturates with CYC_WIDTH=4 after 15 accesses.
